// File: rtl/display7_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : display7_scan
// Description : Time-multiplexed driver for a bank of common-anode 7-segment
//               digits. A refresh prescaler holds each digit for CLK_DIV
//               cycles while a scan index walks digits 0..DIGITS-1. Values
//               are written into a shadow register and only copied into the
//               display register at the end of a full scan, so a frame is
//               never shown half-old / half-new. Supports per-digit enable,
//               per-digit decimal point and leading-zero blanking.
//
// Ports       : iClk    - clock, all state on rising edge
//               iRst    - synchronous reset, active-high
//               iData   - DIGITS hex nibbles, digit k = iData[4k+3:4k]
//               iDp     - decimal point per digit (1 = lit)
//               iEn     - digit enable (0 = digit dark)
//               iLzb    - leading-zero blanking enable (live, not shadowed)
//               iLoad   - one-cycle strobe, capture iData/iDp/iEn
//               oSeg    - segments {g,f,e,d,c,b,a}
//               oDp     - decimal-point segment
//               oAn     - digit select, one-hot at the active level
//               oFrame  - one-cycle pulse after each completed scan
//
// Revision    : 1.0 - initial release
// ============================================================================
module display7_scan #(
    parameter int DIGITS         = 8,
    parameter int CLK_DIV        = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic [4*DIGITS-1:0]   iData,
    input  logic [DIGITS-1:0]     iDp,
    input  logic [DIGITS-1:0]     iEn,
    input  logic                  iLzb,
    input  logic                  iLoad,
    output logic [6:0]            oSeg,
    output logic                  oDp,
    output logic [DIGITS-1:0]     oAn,
    output logic                  oFrame
);

    // Counter widths are kept at least 1 bit so the degenerate DIGITS=1 /
    // CLK_DIV=1 configurations still elaborate cleanly.
    localparam int c_IDX_W = (DIGITS  > 1) ? $clog2(DIGITS)  : 1;
    localparam int c_PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(CLK_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_MAX = c_IDX_W'(DIGITS - 1);

    // Output levels for "off" at the pins.
    localparam logic [6:0]        c_SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic              c_DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] c_AN_OFF  = {DIGITS{AN_ACTIVE_LOW}};

    // Hex to active-high segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_PRE_W-1:0]   prescaler_q,   prescaler_d;
    logic [c_IDX_W-1:0]   index_q,       index_d;
    logic [4*DIGITS-1:0]  shadow_data_q, shadow_data_d;
    logic [DIGITS-1:0]    shadow_dp_q,   shadow_dp_d;
    logic [DIGITS-1:0]    shadow_en_q,   shadow_en_d;
    logic                 pending_q,     pending_d;
    logic [4*DIGITS-1:0]  disp_data_q,   disp_data_d;
    logic [DIGITS-1:0]    disp_dp_q,     disp_dp_d;
    logic [DIGITS-1:0]    disp_en_q,     disp_en_d;
    logic [6:0]           seg_q,         seg_d;
    logic                 dp_q,          dp_d;
    logic [DIGITS-1:0]    an_q,          an_d;
    logic                 frame_q,       frame_d;

    logic tick;
    logic wrap;

    // ------------------------------------------------------------------
    // Prescaler, scan index and shadow/display transfer
    // ------------------------------------------------------------------
    always_comb begin
        tick          = (prescaler_q == c_PRE_MAX);
        wrap          = tick && (index_q == c_IDX_MAX);

        prescaler_d   = tick ? '0 : prescaler_q + c_PRE_W'(1);

        index_d       = index_q;
        if (tick) begin
            index_d = (index_q == c_IDX_MAX) ? '0 : index_q + c_IDX_W'(1);
        end

        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        shadow_en_d   = shadow_en_q;
        pending_d     = pending_q;
        disp_data_d   = disp_data_q;
        disp_dp_d     = disp_dp_q;
        disp_en_d     = disp_en_q;

        if (iLoad) begin
            shadow_data_d = iData;
            shadow_dp_d   = iDp;
            shadow_en_d   = iEn;
        end

        if (wrap) begin
            // A load landing on the wrap tick bypasses the shadow so the
            // freshest value is what the next frame shows.
            if (iLoad) begin
                disp_data_d = iData;
                disp_dp_d   = iDp;
                disp_en_d   = iEn;
            end else if (pending_q) begin
                disp_data_d = shadow_data_q;
                disp_dp_d   = shadow_dp_q;
                disp_en_d   = shadow_en_q;
            end
            pending_d = 1'b0;
        end else if (iLoad) begin
            pending_d = 1'b1;
        end

        frame_d = wrap;
    end

    // ------------------------------------------------------------------
    // Digit selection, blanking and decode
    // ------------------------------------------------------------------
    logic [DIGITS-1:0] lz_blank;
    logic              zero_above;
    logic [3:0]        sel_nib;
    logic              sel_en;
    logic              sel_dp;
    logic              sel_lz;
    logic              blank;
    logic [DIGITS-1:0] an_onehot;

    always_comb begin
        // Walk from the most significant digit down: a digit is a leading
        // zero when it and every digit above it hold zero. Digit 0 always
        // shows, so a value of zero still displays "0".
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above  = zero_above && (disp_data_q[4*k +: 4] == 4'h0);
            lz_blank[k] = zero_above && (k != 0);
        end

        sel_nib   = 4'h0;
        sel_en    = 1'b0;
        sel_dp    = 1'b0;
        sel_lz    = 1'b0;
        an_onehot = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (index_q == c_IDX_W'(k)) begin
                sel_nib      = disp_data_q[4*k +: 4];
                sel_en       = disp_en_q[k];
                sel_dp       = disp_dp_q[k];
                sel_lz       = lz_blank[k];
                an_onehot[k] = 1'b1;
            end
        end

        // iLzb is taken live so blanking can be toggled without a reload.
        blank = !sel_en || (iLzb && sel_lz);

        if (blank) begin
            seg_d = c_SEG_OFF;
            dp_d  = c_DP_OFF;
            an_d  = c_AN_OFF;
        end else begin
            seg_d = hex_to_seg(sel_nib) ^ {7{SEG_ACTIVE_LOW}};
            dp_d  = sel_dp ^ SEG_ACTIVE_LOW;
            an_d  = an_onehot ^ c_AN_OFF;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (iRst) begin
            prescaler_q   <= '0;
            index_q       <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            shadow_en_q   <= '0;
            pending_q     <= 1'b0;
            disp_data_q   <= '0;
            disp_dp_q     <= '0;
            disp_en_q     <= '0;
            seg_q         <= c_SEG_OFF;
            dp_q          <= c_DP_OFF;
            an_q          <= c_AN_OFF;
            frame_q       <= 1'b0;
        end else begin
            prescaler_q   <= prescaler_d;
            index_q       <= index_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            shadow_en_q   <= shadow_en_d;
            pending_q     <= pending_d;
            disp_data_q   <= disp_data_d;
            disp_dp_q     <= disp_dp_d;
            disp_en_q     <= disp_en_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            frame_q       <= frame_d;
        end
    end

    assign oSeg   = seg_q;
    assign oDp    = dp_q;
    assign oAn    = an_q;
    assign oFrame = frame_q;

endmodule
`default_nettype wire
